demux4_buf: RTL
===============

Name: demux4_buf

Overview:
- Registered 1-to-4 demultiplexer: the distribution end of the datapath's 4-input select path.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it by a 2-bit select to one of four output channels A/B/C/D.
- Each channel holds the word in its own single-entry holding register until that channel's consumer takes it.
- Sits after result/write-back generation, fanning one producer out to four consumers (e.g. register-file write port, memory write data, PC path, debug).

Parameters:
WIDTH, 32, data width of input and each output channel
CNT_W, 16, width of per-channel transfer counters

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept the input word this cycle
in_sel  input  2  destination: 0=A, 1=B, 2=C, 3=D
in_data  input  WIDTH  input word
out_valid  output  4  bit i = channel i holds a word (bit0=A ... bit3=D)
out_ready  input  4  bit i = channel i consumer takes the word this cycle
out_a  output  WIDTH  channel A holding register
out_b  output  WIDTH  channel B holding register
out_c  output  WIDTH  channel C holding register
out_d  output  WIDTH  channel D holding register
cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  words delivered on each channel since reset

Behaviour:
Clocking and reset:
- Single clock domain, synchronous active-high reset; all state updates on posedge clk.
- While rst=1 at a clock edge: out_valid=4'b0000, out_a..out_d=0, cnt_a..cnt_d=0.
- Reset overrides any transfer in the same cycle. A word held at reset is discarded and not counted.

Per-channel state machine (channel i, two states):
- EMPTY -> FULL: on input accept targeting i.
- FULL -> EMPTY: when out_ready[i]=1 and no accept targets i that cycle.
- FULL -> FULL (reload): when out_ready[i]=1 and an accept targets i in the same cycle. The register loads the new word with no bubble.
- FULL with out_ready[i]=0 holds the word and data stable; the consumer sees no change.

Handshake:
- in_ready is combinational: in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It depends only on the selected channel.
- Accept condition: in_valid & in_ready.
- Input-to-output latency: a word accepted at edge N appears on out_x with out_valid set after edge N (1 cycle). No combinational path from in_data to out_x.
- Channel delivery: out_valid[i] & out_ready[i] at an edge. cnt_i increments by 1 on each delivery. The counter wraps modulo 2^CNT_W (max value to 0); no saturation.
- out_ready[i] while out_valid[i]=0 is ignored; no count.
- A full channel does not block other channels. Accepting into channel j while channel i is stalled is legal.
- in_sel and in_data are sampled only on accept. Changes while in_valid=0 or in_ready=0 have no effect.
- An output register's data changes only on load; between deliveries it keeps its last value.
- Channels deliver independently. Up to four deliveries and one accept may occur at the same edge.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_sel=2, in_data=32'hDEAD_BEEF -> after release out_valid=0000, all outs 0, all cnt=0, no word loaded.
- Basic route: out_ready=4'b1111; send 32'h1111_1111 sel0, 32'h2222_2222 sel1, 32'h3333_3333 sel2, 32'h4444_4444 sel3 back-to-back -> each appears on its channel exactly 1 cycle after accept; in_ready stays 1; cnt_a..cnt_d=1 each.
- Backpressure: out_ready[1]=0; send 32'hAAAA_0001 sel1, then 32'hAAAA_0002 sel1 -> second word stalls (in_ready=0), out_b holds 32'hAAAA_0001. Raise out_ready[1] -> same edge delivers word 1 and loads word 2; cnt_b=1, then 2 after the next cycle.
- Non-blocking: channel B stalled full; send 32'h0000_00C0 sel2 -> in_ready=1, accepted, out_c=32'h0000_00C0 next cycle, out_b unchanged.
- Counter wrap: CNT_W=4; deliver 17 words on channel D -> cnt_d sequence reaches 15, wraps to 0, ends at 1.
- Reset mid-operation: channels A and C full and stalled; pulse rst 1 cycle -> out_valid=0000, data 0, counters 0; the next accepted word on A is delivered normally with cnt_a=1.

Source files
------------

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: one valid/ready input steered by a 2-bit select
// into four single-entry channel holding registers, each with a delivery counter.
module demux4_buf #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c,
   output logic [CNT_W-1:0] cnt_d
);

   // Per-channel FSM
   //   state | meaning
   //   EMPTY | holding register free, out_valid[i]=0
   //   FULL  | holding register holds a word, out_valid[i]=1
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_e;

   chan_state_e      state_q [4];
   logic [WIDTH-1:0] data_q  [4];
   logic [CNT_W-1:0] cnt_q   [4];

   logic             accept;
   logic [3:0]       load;
   logic [3:0]       deliver;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         out_valid[i] = (state_q[i] == FULL);
      end
   end

   assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
   assign accept   = in_valid & in_ready;
   assign deliver  = out_valid & out_ready;

   always_comb begin
      load = 4'b0000;
      if (accept) begin
         load[in_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= EMPTY;
            data_q[i]  <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            case (state_q[i])
               EMPTY: begin
                  if (load[i]) begin
                     state_q[i] <= FULL;
                     data_q[i]  <= in_data;
                  end
               end
               FULL: begin
                  // a load in the delivery cycle reloads with no bubble
                  if (load[i]) begin
                     data_q[i] <= in_data;
                  end else if (out_ready[i]) begin
                     state_q[i] <= EMPTY;
                  end
               end
               default: state_q[i] <= EMPTY;
            endcase
            if (deliver[i]) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign out_a = data_q[0];
   assign out_b = data_q[1];
   assign out_c = data_q[2];
   assign out_d = data_q[3];
   assign cnt_a = cnt_q[0];
   assign cnt_b = cnt_q[1];
   assign cnt_c = cnt_q[2];
   assign cnt_d = cnt_q[3];

endmodule
